// File: rtl/fetch_unit.sv
// Instruction fetch stage: single outstanding zero-wait request to imem, with
// a one-entry hold buffer for freeze and drop-on-redirect handling.
//   state     | meaning
//   S_FETCH   | request to pc outstanding, data forwarded on ready
//   S_HOLD    | fetched instruction buffered until freeze drops
//   S_DISCARD | stale request held until ready, then dropped
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] instruction_out,
   output logic        valid_out
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_HOLD    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic [31:0] pc_inc;
   logic [31:0] br_target;

   assign pc_inc    = pc_q + 32'd4;
   assign br_target = branch_addr & 32'hFFFF_FFFC;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         hold_pc_q    <= 32'h0;
         hold_instr_q <= 32'h0;
         drop_addr_q  <= RESET_PC;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         hold_pc_q    <= hold_pc_d;
         hold_instr_q <= hold_instr_d;
         drop_addr_q  <= drop_addr_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      hold_pc_d       = hold_pc_q;
      hold_instr_d    = hold_instr_q;
      drop_addr_d     = drop_addr_q;
      imem_req        = 1'b1;
      imem_addr       = pc_q;
      valid_out       = 1'b0;
      pc_out          = pc_q;
      instruction_out = 32'h0;

      case (state_q)
         S_FETCH: begin
            if (branch_taken) begin
               pc_d = br_target;
               if (!imem_ready) begin
                  state_d     = S_DISCARD;
                  drop_addr_d = pc_q;
               end
            end else if (imem_ready) begin
               valid_out       = 1'b1;
               pc_out          = pc_inc;
               instruction_out = imem_rdata;
               pc_d            = pc_inc;
               if (freeze) begin
                  state_d      = S_HOLD;
                  hold_pc_d    = pc_inc;
                  hold_instr_d = imem_rdata;
               end
            end
         end
         S_HOLD: begin
            imem_req = 1'b0;
            if (branch_taken) begin
               pc_d    = br_target;
               state_d = S_FETCH;
            end else begin
               valid_out       = 1'b1;
               pc_out          = hold_pc_q;
               instruction_out = hold_instr_q;
               if (!freeze) state_d = S_FETCH;
            end
         end
         S_DISCARD: begin
            // The dropped request keeps its own address; pc already holds the redirect.
            imem_addr = drop_addr_q;
            if (branch_taken) pc_d = br_target;
            if (imem_ready) state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      if (rst) begin
         valid_out       = 1'b0;
         pc_out          = pc_q;
         instruction_out = 32'h0;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns addr^A5A5_0000, valid outputs
// are scoreboarded, request/bubble signals checked each cycle.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] instruction_out;
   logic        valid_out;

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] sb_q[$];

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .freeze          (freeze),
      .branch_taken    (branch_taken),
      .branch_addr     (branch_addr),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .pc_out          (pc_out),
      .instruction_out (instruction_out),
      .valid_out       (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Every valid_out cycle must match the oldest expected transfer.
   always @(negedge clk) begin
      logic [63:0] e;
      if (rst === 1'b0 && valid_out === 1'b1) begin
         n_checks++;
         assert (sb_q.size() > 0) else begin
            n_fail++;
            $error("FAIL sb_unexpected observed=%h/%h expected=none", pc_out, instruction_out);
         end
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_pc", pc_out, e[63:32]);
            chk("sb_instr", instruction_out, e[31:0]);
         end
      end
   end

   // One cycle: drive at posedge+1, check at negedge, return at next posedge+1.
   task automatic cyc(input logic rdy, input logic frz, input logic br, input logic [31:0] baddr,
                      input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                      input logic [31:0] e_pc, input logic [31:0] e_instr);
      imem_ready   = rdy;
      freeze       = frz;
      branch_taken = br;
      branch_addr  = baddr;
      if (e_valid) sb_q.push_back({e_pc, e_instr});
      @(negedge clk);
      chk("imem_req", {31'h0, imem_req}, {31'h0, e_req});
      if (e_req) chk("imem_addr", imem_addr, e_addr);
      chk("valid_out", {31'h0, valid_out}, {31'h0, e_valid});
      if (!e_valid) begin
         chk("bubble_pc", pc_out, e_pc);
         chk("bubble_instr", instruction_out, 32'h0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; imem_ready = 1'b1; freeze = 1'b0;
      branch_taken = 1'b0; branch_addr = 32'h0;
      @(negedge clk);
      chk("rst_req", {31'h0, imem_req}, 32'h1);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'h0, valid_out}, 32'h0);
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_instr", instruction_out, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // zero-wait stream, then freeze for 2 cycles on the data for addr 8
      cyc(1, 0, 0, 0,     1, 32'h0, 1, 32'h4, mem_data(32'h0));
      cyc(1, 0, 0, 0,     1, 32'h4, 1, 32'h8, mem_data(32'h4));
      cyc(1, 1, 0, 0,     1, 32'h8, 1, 32'hC, mem_data(32'h8));
      cyc(0, 1, 0, 0,     0, 32'h0, 1, 32'hC, mem_data(32'h8));
      cyc(0, 0, 0, 0,     0, 32'h0, 1, 32'hC, mem_data(32'h8));
      // three wait states on addr 12
      cyc(0, 0, 0, 0,     1, 32'hC, 0, 32'hC, 32'h0);
      cyc(0, 0, 0, 0,     1, 32'hC, 0, 32'hC, 32'h0);
      cyc(0, 0, 0, 0,     1, 32'hC, 0, 32'hC, 32'h0);
      cyc(1, 0, 0, 0,     1, 32'hC, 1, 32'h10, mem_data(32'hC));
      // redirect while request for 0x10 pending; ready two cycles later
      cyc(0, 0, 1, 32'h100, 1, 32'h10, 0, 32'h10, 32'h0);
      cyc(0, 0, 0, 0,       1, 32'h10, 0, 32'h100, 32'h0);
      cyc(1, 0, 0, 0,       1, 32'h10, 0, 32'h100, 32'h0);
      cyc(1, 0, 0, 0,       1, 32'h100, 1, 32'h104, mem_data(32'h100));
      // branch + freeze + ready together; low address bits dropped
      cyc(1, 1, 1, 32'h203, 1, 32'h104, 0, 32'h104, 32'h0);
      cyc(1, 1, 0, 0,       1, 32'h200, 1, 32'h204, mem_data(32'h200));
      // branch while holding
      cyc(0, 1, 1, 32'h300, 0, 32'h0,   0, 32'h204, 32'h0);
      cyc(1, 0, 0, 0,       1, 32'h300, 1, 32'h304, mem_data(32'h300));
      // redirect in DISCARD: latest target wins
      cyc(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h304, 0, 32'h304, 32'h0);
      cyc(0, 0, 1, 32'h400,       1, 32'h304, 0, 32'hFFFF_FFFC, 32'h0);
      cyc(1, 0, 0, 0,             1, 32'h304, 0, 32'h400, 32'h0);
      cyc(1, 0, 0, 0,             1, 32'h400, 1, 32'h404, mem_data(32'h400));
      // into DISCARD again, then async reset between edges
      cyc(0, 0, 1, 32'h500,       1, 32'h404, 0, 32'h404, 32'h0);
      #2;
      imem_ready = 1'b1;
      rst = 1'b1;
      #1;
      chk("arst_req", {31'h0, imem_req}, 32'h1);
      chk("arst_addr", imem_addr, 32'h0);
      chk("arst_valid", {31'h0, valid_out}, 32'h0);
      chk("arst_pc", pc_out, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      // first post-reset fetch is RESET_PC; redirect on ready, then wrap
      cyc(1, 0, 1, 32'hFFFF_FFFC, 1, 32'h0, 0, 32'h0, 32'h0);
      cyc(1, 0, 0, 0,             1, 32'hFFFF_FFFC, 1, 32'h0, mem_data(32'hFFFF_FFFC));
      cyc(1, 0, 0, 0,             1, 32'h0, 1, 32'h4, mem_data(32'h0));
      imem_ready = 1'b0;
      @(negedge clk);
      chk("sb_drained", sb_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 freeze  input  1  downstream IF/ID register is holding; a presented instruction is not consumed this cycle.
REQ-005 branch_taken  input  1  one-cycle redirect pulse from execute.
REQ-006 branch_addr  input  32  redirect target; sampled only when branch_taken=1.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  request address; word aligned.
REQ-009 imem_ready  input  1  memory accepts the request and returns data in the same cycle.
REQ-010 imem_rdata  input  32  returned instruction; valid only when imem_req&imem_ready.
REQ-011 pc_out  output  32  fetched address + 4, to the IF/ID pc input.
REQ-012 instruction_out  output  32  fetched instruction, to the IF/ID instruction input.
REQ-013 valid_out  output  1  pc_out/instruction_out carry a real instruction this cycle.

Function
REQ-014 States: FETCH (request outstanding), HOLD (instruction buffered, waiting for freeze=0), DISCARD (outstanding request to be dropped after a redirect).
REQ-015 Registers: pc (32b, next fetch address), hold_pc, hold_instr, state.
REQ-016 Memory protocol: imem_req=1 in FETCH and DISCARD, 0 in HOLD; imem_addr and imem_req stay stable until the cycle imem_ready=1.
REQ-017 imem_addr = pc in FETCH. In DISCARD it equals the address of the request being dropped, kept in a register.
REQ-018 Zero-wait: imem_ready may be 1 in the first cycle of a request. Latency from request to pc_out/instruction_out is 0 cycles. Both outputs are combinational from imem_rdata.
REQ-019 FETCH, imem_ready=1, branch_taken=0, freeze=0:
  - outputs are pc+4, imem_rdata, with valid_out=1.
  - pc <= pc+4; stay in FETCH.
REQ-020 FETCH, imem_ready=1, branch_taken=0, freeze=1:
  - hold_pc <= pc+4; hold_instr <= imem_rdata.
  - pc <= pc+4; go to HOLD.
REQ-021 FETCH, imem_ready=0, branch_taken=0: valid_out=0; state and pc unchanged.
REQ-022 HOLD: outputs are hold_pc, hold_instr, with valid_out=1. When freeze=0, go to FETCH next cycle. The next fetch starts one cycle later.
REQ-023 Bubble: when valid_out=0, instruction_out=32'h0 and pc_out=pc.
REQ-024 branch_taken=1 has priority over freeze and over any returning data in every state:
  - pc <= branch_addr; valid_out=0 this cycle.
  - The hold buffer is invalidated.
REQ-025 branch_taken in FETCH with imem_ready=1: imem_rdata is dropped; next state FETCH at branch_addr.
REQ-026 branch_taken in FETCH with imem_ready=0: next state DISCARD.
REQ-027 DISCARD: the request is kept stable until imem_ready=1. Those data are dropped with valid_out=0, and the next state is FETCH at the redirected pc.
REQ-028 branch_taken in DISCARD: pc <= branch_addr (latest redirect wins); state stays DISCARD.
REQ-029 branch_taken in HOLD: next state FETCH at branch_addr; no data is output.
REQ-030 pc+4 wraps modulo 2^32; 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-031 The low 2 bits of branch_addr are ignored and forced to 0 in pc.

Reset
REQ-032 While rst=1:
  - state=FETCH, pc=RESET_PC; hold buffer invalid.
  - imem_req=1, imem_addr=RESET_PC.
  - valid_out=0, instruction_out=0, pc_out=RESET_PC.
REQ-033 Reset mid-request abandons the outstanding fetch; the first post-reset request is to RESET_PC.

Verification
REQ-034 Zero-wait stream:
  - stimulus: imem_ready=1 constantly, imem_rdata=addr^32'hA5A5_0000.
  - response: valid_out=1 every cycle; pc_out sequence 4,8,12.
REQ-035 Wait states:
  - stimulus: imem_ready low 3 cycles then high.
  - response: imem_addr stable 4 cycles; valid_out=1 only in cycle 4.
REQ-036 Freeze capture:
  - stimulus: freeze=1 for 2 cycles when the data for addr 8 return.
  - response: pc_out=12 held with imem_req=0; request for 12 starts the cycle after freeze=0.
REQ-037 Redirect while waiting:
  - stimulus: branch_taken, branch_addr=32'h100 while the request for 32'h10 is pending; ready 2 cycles later.
  - response: the data for 32'h10 are dropped with valid_out=0; the next imem_addr is 32'h100.
REQ-038 Simultaneous branch, freeze and ready:
  - stimulus: all three in one cycle.
  - response: valid_out=0; no HOLD; next imem_addr=branch_addr.
REQ-039 Async reset:
  - stimulus: rst asserted between clock edges during DISCARD.
  - response: imem_addr=RESET_PC and valid_out=0 immediately.
  - Wrap check: pc 32'hFFFF_FFFC then 32'h0.
